// File: rtl/sim_serial_bridge.sv
// sim_serial_bridge: simulation-only serial tether between a target's
// serial_out/serial_in channels and a host-side stream pair.
//   - TX path: serial_out -> TX FIFO -> host_tx
//   - RX path: host_rx    -> RX FIFO -> serial_in
//   - In-band exit command on serial_out (EXIT_CMD followed by a code word)
//     raises a sticky exit flag and captures exit_code.
// Optional feature macro: SIM_SERIAL_WATCHDOG_EN. When defined, an idle
// watchdog forces exit with an all-ones code after TIMEOUT_CYCLES quiet
// cycles. When undefined, no watchdog is built.

// Single-clock first-word-fall-through FIFO, no bypass path.
module sim_serial_bridge_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_bits,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_bits,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;

  // Ready comes only from the registered count, so a pop in the same
  // cycle cannot re-open a full FIFO until the following cycle.
  assign in_ready  = (count_q != FullCount);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Output data is forced to zero whenever nothing is presented.
  assign out_bits  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; stale entries are
    // unreachable once the pointers and count are cleared, and out_bits is
    // masked while the FIFO is empty.
    if (push) mem_q[wr_ptr_q] <= in_bits;
  end

endmodule

// Top level: two FIFOs plus the exit-command decoder.
module sim_serial_bridge #(
  parameter int               W              = 32,
  parameter int               DEPTH          = 8,
  parameter logic [W-1:0]     EXIT_CMD       = W'(32'hDEAD_E0E0),
  parameter int               TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    serial_out_valid,
  output logic                    serial_out_ready,
  input  logic [W-1:0]            serial_out_bits,
  output logic                    serial_in_valid,
  input  logic                    serial_in_ready,
  output logic [W-1:0]            serial_in_bits,
  output logic                    host_tx_valid,
  input  logic                    host_tx_ready,
  output logic [W-1:0]            host_tx_bits,
  input  logic                    host_rx_valid,
  output logic                    host_rx_ready,
  input  logic [W-1:0]            host_rx_bits,
  output logic                    exit,
  output logic [W-1:0]            exit_code,
  output logic [$clog2(DEPTH):0]  tx_count,
  output logic [$clog2(DEPTH):0]  rx_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_CMD,
    ST_DONE
  } state_e;

  state_e       state_q, state_d;
  logic         exit_q, exit_d;
  logic [W-1:0] exit_code_q, exit_code_d;

  logic tx_in_ready;
  logic tx_push;
  logic so_fire;
  logic si_fire;
  logic ht_fire;
  logic hr_fire;
  logic wd_fire;

  // TX path: target words that are not part of the exit sequence.
  sim_serial_bridge_fifo #(.W(W), .DEPTH(DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (tx_push),
    .in_ready  (tx_in_ready),
    .in_bits   (serial_out_bits),
    .out_valid (host_tx_valid),
    .out_ready (host_tx_ready),
    .out_bits  (host_tx_bits),
    .count     (tx_count)
  );

  // RX path: host words to the target, independent of exit state.
  sim_serial_bridge_fifo #(.W(W), .DEPTH(DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (host_rx_valid),
    .in_ready  (host_rx_ready),
    .in_bits   (host_rx_bits),
    .out_valid (serial_in_valid),
    .out_ready (serial_in_ready),
    .out_bits  (serial_in_bits),
    .count     (rx_count)
  );

  // serial_out ready depends only on FSM state and TX occupancy.
  always_comb begin
    serial_out_ready = 1'b0;
    case (state_q)
      ST_IDLE:    serial_out_ready = tx_in_ready;
      ST_GOT_CMD: serial_out_ready = 1'b1;
      default:    serial_out_ready = 1'b0;
    endcase
  end

  assign so_fire = serial_out_valid && serial_out_ready;
  assign si_fire = serial_in_valid  && serial_in_ready;
  assign ht_fire = host_tx_valid    && host_tx_ready;
  assign hr_fire = host_rx_valid    && host_rx_ready;

  // Only ordinary words accepted in IDLE reach the TX FIFO.
  assign tx_push = so_fire && (state_q == ST_IDLE) && (serial_out_bits != EXIT_CMD);

`ifdef SIM_SERIAL_WATCHDOG_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] IdleLimit = IW'(TIMEOUT_CYCLES - 1);

  logic          any_fire;
  logic [IW-1:0] idle_cnt_q;

  assign any_fire = so_fire || si_fire || ht_fire || hr_fire;
  // Fires on the quiet cycle in which the count has reached its limit; any
  // handshake that cycle (including a GOT_CMD code word) suppresses it.
  assign wd_fire  = (idle_cnt_q == IdleLimit) && !any_fire && !exit_q;

  // Idle counter: cleared by any handshake, counts only while not exited.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else if (any_fire) begin
      idle_cnt_q <= '0;
    end else if (!exit_q && (idle_cnt_q != IdleLimit)) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  logic unused_watchdog;

  assign wd_fire         = 1'b0;
  // Handshake strobes and the timeout only matter to the watchdog.
  assign unused_watchdog = si_fire ^ ht_fire ^ hr_fire ^ (TIMEOUT_CYCLES != 0);
`endif

  // Exit-sequence next-state: IDLE -> GOT_CMD -> DONE, left only by reset.
  always_comb begin
    state_d     = state_q;
    exit_d      = exit_q;
    exit_code_d = exit_code_q;
    case (state_q)
      ST_IDLE: begin
        if (so_fire && (serial_out_bits == EXIT_CMD)) state_d = ST_GOT_CMD;
      end
      ST_GOT_CMD: begin
        // Any word here, EXIT_CMD included, is the exit code.
        if (so_fire) begin
          exit_code_d = serial_out_bits;
          exit_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: state_d = ST_DONE;
    endcase
    if (wd_fire) begin
      exit_code_d = '1;
      exit_d      = 1'b1;
      state_d     = ST_DONE;
    end
  end

  // Exit-sequence registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      exit_q      <= 1'b0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      exit_q      <= exit_d;
      exit_code_q <= exit_code_d;
    end
  end

  assign exit      = exit_q;
  assign exit_code = exit_code_q;

endmodule

// File: tb/tb_sim_serial_bridge.sv
// Directed self-checking bench for sim_serial_bridge (W=32, DEPTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
// The watchdog section runs only when SIM_SERIAL_WATCHDOG_EN is defined.
module tb_sim_serial_bridge;

  localparam int W        = 32;
  localparam int DEPTH    = 8;
  localparam logic [31:0] EXIT_CMD = 32'hDEAD_E0E0;

  logic        clock;
  logic        reset_n;
  logic        serial_out_valid;
  logic        serial_out_ready;
  logic [31:0] serial_out_bits;
  logic        serial_in_valid;
  logic        serial_in_ready;
  logic [31:0] serial_in_bits;
  logic        host_tx_valid;
  logic        host_tx_ready;
  logic [31:0] host_tx_bits;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic [31:0] host_rx_bits;
  logic        exit;
  logic [31:0] exit_code;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;

  int n_cmp  = 0;
  int n_fail = 0;

  sim_serial_bridge #(
    .W              (W),
    .DEPTH          (DEPTH),
    .EXIT_CMD       (EXIT_CMD),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .serial_out_valid (serial_out_valid),
    .serial_out_ready (serial_out_ready),
    .serial_out_bits  (serial_out_bits),
    .serial_in_valid  (serial_in_valid),
    .serial_in_ready  (serial_in_ready),
    .serial_in_bits   (serial_in_bits),
    .host_tx_valid    (host_tx_valid),
    .host_tx_ready    (host_tx_ready),
    .host_tx_bits     (host_tx_bits),
    .host_rx_valid    (host_rx_valid),
    .host_rx_ready    (host_rx_ready),
    .host_rx_bits     (host_rx_bits),
    .exit             (exit),
    .exit_code        (exit_code),
    .tx_count         (tx_count),
    .rx_count         (rx_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Hold reset low for the given number of rising edges, inputs idle.
  task automatic do_reset(input int cycles);
    reset_n          = 1'b0;
    serial_out_valid = 1'b0;
    serial_out_bits  = '0;
    serial_in_ready  = 1'b0;
    host_tx_ready    = 1'b0;
    host_rx_valid    = 1'b0;
    host_rx_bits     = '0;
    repeat (cycles) cyc();
    reset_n = 1'b1;
  endtask

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  initial begin
    @(negedge clock);
    do_reset(2);

    // ---- Reset state ----
    check("rst_tx_count",   32'(tx_count), 32'd0);
    check("rst_rx_count",   32'(rx_count), 32'd0);
    check("rst_exit",       32'(exit), 32'd0);
    check("rst_exit_code",  exit_code, 32'd0);
    check("rst_htx_valid",  32'(host_tx_valid), 32'd0);
    check("rst_htx_bits",   host_tx_bits, 32'd0);
    check("rst_sin_valid",  32'(serial_in_valid), 32'd0);
    check("rst_sin_bits",   serial_in_bits, 32'd0);
    check("rst_so_ready",   32'(serial_out_ready), 32'd1);
    check("rst_hrx_ready",  32'(host_rx_ready), 32'd1);

    // ---- Test 1: three words, latency 1 ----
    host_tx_ready    = 1'b1;
    serial_out_valid = 1'b1;
    serial_out_bits  = 32'h11;
    cyc();
    check("t1_valid0", 32'(host_tx_valid), 32'd1);
    check("t1_bits0",  host_tx_bits, 32'h11);
    serial_out_bits = 32'h22;
    cyc();
    check("t1_bits1",  host_tx_bits, 32'h22);
    serial_out_bits = 32'h33;
    cyc();
    check("t1_bits2",  host_tx_bits, 32'h33);
    serial_out_valid = 1'b0;
    cyc();
    check("t1_empty_valid", 32'(host_tx_valid), 32'd0);
    check("t1_empty_bits",  host_tx_bits, 32'd0);
    check("t1_count",       32'(tx_count), 32'd0);

    // ---- Test 2: fill to full, then drain ----
    host_tx_ready    = 1'b0;
    serial_out_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      serial_out_bits = 32'h100 + 32'(i);
      cyc();
    end
    check("t2_full_count", 32'(tx_count), 32'd8);
    check("t2_full_ready", 32'(serial_out_ready), 32'd0);
    serial_out_bits = 32'h108;
    cyc();
    serial_out_bits = 32'h109;
    cyc();
    check("t2_held_count", 32'(tx_count), 32'd8);
    check("t2_held_ready", 32'(serial_out_ready), 32'd0);
    serial_out_valid = 1'b0;
    host_tx_ready    = 1'b1;
    check("t2_pop_cycle_ready", 32'(serial_out_ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain_valid", 32'(host_tx_valid), 32'd1);
      check("t2_drain_bits",  host_tx_bits, 32'h100 + 32'(i));
      cyc();
      if (i == 0) check("t2_reopen_ready", 32'(serial_out_ready), 32'd1);
    end
    check("t2_drained_valid", 32'(host_tx_valid), 32'd0);
    check("t2_drained_count", 32'(tx_count), 32'd0);

    // ---- Test 3: continuous push+pop, 20 words ----
    serial_out_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      serial_out_bits = 32'h200 + 32'(i);
      cyc();
      check("t3_bits",  host_tx_bits, 32'h200 + 32'(i));
      check("t3_count", 32'(tx_count), 32'd1);
    end
    serial_out_valid = 1'b0;
    cyc();
    check("t3_final_count", 32'(tx_count), 32'd0);

    // ---- Test 4: 0x5, EXIT_CMD, 0x2A; then RX path ----
    serial_out_valid = 1'b1;
    serial_out_bits  = 32'h5;
    cyc();
    check("t4_word", host_tx_bits, 32'h5);
    check("t4_cmd_ready", 32'(serial_out_ready), 32'd1);
    serial_out_bits = EXIT_CMD;
    cyc();
    check("t4_cmd_not_enq", 32'(host_tx_valid), 32'd0);
    check("t4_gotcmd_ready", 32'(serial_out_ready), 32'd1);
    check("t4_exit_pending", 32'(exit), 32'd0);
    serial_out_bits = 32'h2A;
    cyc();
    check("t4_exit", 32'(exit), 32'd1);
    check("t4_exit_code", exit_code, 32'h2A);
    check("t4_done_ready", 32'(serial_out_ready), 32'd0);
    check("t4_code_not_enq", 32'(host_tx_valid), 32'd0);
    serial_out_bits = 32'h99;
    cyc();
    cyc();
    check("t4_done_ready_hold", 32'(serial_out_ready), 32'd0);
    check("t4_done_tx_count",   32'(tx_count), 32'd0);
    check("t4_exit_sticky",     32'(exit), 32'd1);
    serial_out_valid = 1'b0;
    host_rx_valid    = 1'b1;
    host_rx_bits     = 32'h77;
    serial_in_ready  = 1'b0;
    check("t4_hrx_ready", 32'(host_rx_ready), 32'd1);
    cyc();
    host_rx_valid = 1'b0;
    check("t4_sin_valid", 32'(serial_in_valid), 32'd1);
    check("t4_sin_bits",  serial_in_bits, 32'h77);
    check("t4_rx_count",  32'(rx_count), 32'd1);
    serial_in_ready = 1'b1;
    cyc();
    check("t4_sin_empty", 32'(serial_in_valid), 32'd0);
    check("t4_sin_bits0", serial_in_bits, 32'd0);
    check("t4_rx_count0", 32'(rx_count), 32'd0);

    // ---- Test 5: reset with tx_count=3 and exit=1 ----
    do_reset(1);
    serial_out_valid = 1'b1;
    serial_out_bits  = 32'hA1;
    cyc();
    serial_out_bits = 32'hA2;
    cyc();
    serial_out_bits = 32'hA3;
    cyc();
    serial_out_bits = EXIT_CMD;
    cyc();
    serial_out_bits = 32'h1;
    cyc();
    serial_out_valid = 1'b0;
    check("t5_pre_count", 32'(tx_count), 32'd3);
    check("t5_pre_exit",  32'(exit), 32'd1);
    do_reset(1);
    check("t5_tx_count",  32'(tx_count), 32'd0);
    check("t5_rx_count",  32'(rx_count), 32'd0);
    check("t5_exit",      32'(exit), 32'd0);
    check("t5_exit_code", exit_code, 32'd0);
    check("t5_htx_valid", 32'(host_tx_valid), 32'd0);
    check("t5_htx_bits",  host_tx_bits, 32'd0);
    check("t5_sin_valid", 32'(serial_in_valid), 32'd0);
    check("t5_so_ready",  32'(serial_out_ready), 32'd1);
    host_tx_ready    = 1'b1;
    serial_out_valid = 1'b1;
    serial_out_bits  = 32'hB1;
    cyc();
    serial_out_valid = 1'b0;
    check("t5_new_valid", 32'(host_tx_valid), 32'd1);
    check("t5_new_bits",  host_tx_bits, 32'hB1);
    cyc();
    check("t5_new_count", 32'(tx_count), 32'd0);

`ifdef SIM_SERIAL_WATCHDOG_EN
    // ---- Test 6: idle watchdog, TIMEOUT_CYCLES=16 ----
    do_reset(1);
    repeat (15) cyc();
    check("t6_before_exit", 32'(exit), 32'd0);
    cyc();
    check("t6_exit", 32'(exit), 32'd1);
    check("t6_exit_code", exit_code, 32'hFFFF_FFFF);
    check("t6_done_ready", 32'(serial_out_ready), 32'd0);

    do_reset(1);
    repeat (10) cyc();
    host_rx_valid = 1'b1;
    host_rx_bits  = 32'h3C;
    cyc();
    host_rx_valid = 1'b0;
    repeat (15) cyc();
    check("t6_restart_before", 32'(exit), 32'd0);
    cyc();
    check("t6_restart_exit", 32'(exit), 32'd1);
    check("t6_restart_code", exit_code, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
